light_btn_ctrl: RTL and testbench
=================================

Name: light_btn_ctrl

Overview:
- Front-end controller for the light-level FSM.
- Conditions three raw push-buttons (up, down, off): synchronises, debounces and converts each to a single-cycle, one-hot command pulse.
- Arbitrates simultaneous presses and enforces release-before-next-press.
- Issues an automatic "off" command after a configurable idle period while the light is on. o_button connects directly to the FSM's button input.

Parameters:
- DEBOUNCE_CYCLES, 100000: consecutive cycles a synchronised input must differ from its debounced level before that level flips. Legal range ≥1.
- IDLE_TIMEOUT, 500000000: idle cycles with light on before auto-off. 0 disables auto-off.
- Counter widths are derived internally via $clog2 of these parameters.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous, active-high reset.
- i_btn_raw  in  3  raw asynchronous buttons: [0]=up, [1]=down, [2]=off. Active-high.
- i_light_level  in  3  current FSM light level (0..4). Used only for idle-timer gating.
- o_button  out  3  one-hot command pulse to the FSM, 1 cycle wide. Otherwise 0.
- o_timeout  out  1  1-cycle flag, coincident with an auto-off pulse.
- o_btn_stable  out  3  debounced button levels.

Behaviour:
- Reset: on a clock edge with i_reset=1, the following are cleared:
  - synchroniser flops, o_btn_stable, and all debounce counters
  - idle counter, with state set to IDLE
  - o_button=000 and o_timeout=0
- All outputs are registered.
- Synchroniser: 2 flops per bit. sync[n] reflects i_btn_raw[n] two edges after it is sampled.
- Debounce, per bit, independent:
  - If sync != stable, the counter increments. Otherwise the counter clears to 0.
  - When the counter would reach DEBOUNCE_CYCLES, stable toggles and the counter clears.
  - Any glitch shorter than DEBOUNCE_CYCLES cycles never changes stable.
- Press event: a 0→1 transition of stable[n] is a single-cycle event ev[n].
- State machine (IDLE, HOLD):
  - IDLE, any ev: o_button = highest-priority event, one-hot, asserted the next cycle. Priority is [2] > [1] > [0]. Lower-priority simultaneous events are discarded, not queued. Idle counter clears. Go to HOLD.
  - IDLE, no ev, timer expired: o_button=100 and o_timeout=1 for one cycle. Idle counter clears. Stay in IDLE.
  - HOLD: all ev are ignored and the idle counter is held at 0. When o_btn_stable==000, go to IDLE.
- Idle counter:
  - Counts only in IDLE with i_light_level != 0 and IDLE_TIMEOUT != 0. Otherwise it clears to 0.
  - Expiry occurs when the count reaches IDLE_TIMEOUT-1.
  - The auto-off pulse therefore appears IDLE_TIMEOUT+1 cycles after counting starts.
- Event and expiry in the same cycle: the event wins. No o_timeout; counter cleared.
- Latency: a raw 0→1 change that meets setup before edge E gives:
  - stable rising at edge E+1+DEBOUNCE_CYCLES
  - o_button high during the cycle after edge E+2+DEBOUNCE_CYCLES
  - i.e. DEBOUNCE_CYCLES+3 edges from first sample to o_button, exact.
- Release path: a raw 1→0 change reaches stable with the same debounce latency. Release never generates o_button.
- Reset mid-operation:
  - An in-flight pulse or timeout is dropped.
  - A button held through reset release is re-debounced from stable=0. It produces one fresh pulse DEBOUNCE_CYCLES+3 edges after reset deasserts.
- Invariants:
  - o_button is always 000 or one-hot.
  - Never two o_button pulses without o_btn_stable passing through 000, except for auto-off pulses.

Test Plan (DEBOUNCE_CYCLES=4, IDLE_TIMEOUT=20):
- Single press: raise i_btn_raw=001 for 10 cycles, then 000. → Exactly one o_button=001, 7 edges after first sample. o_btn_stable[0] is high for 10 cycles. No second pulse on release.
- Glitch rejection: i_btn_raw[1] high for 3 cycles, low 2, high 3, then low. → o_btn_stable stays 000 and o_button never asserts.
- Simultaneous press: i_btn_raw=011, stable together. → One pulse o_button=010 only. Then hold 110 without releasing to 000. → No further pulse until all released, then press 001 → o_button=001.
- Auto-off: i_light_level=3, no buttons. → After 21 cycles, o_button=100 and o_timeout=1 for exactly 1 cycle, then counting restarts. With i_light_level=0, no pulse for 100 cycles.
- Timeout/event collision: arrange ev[0] in the cycle the idle count hits 19. → o_button=001, o_timeout stays 0, counter cleared. Next auto-off occurs only after the release and a further 21 idle cycles.
- Reset mid-press: hold i_btn_raw=100, assert i_reset for 2 cycles right after stable rises. → All outputs 0 during reset. Exactly one o_button=100, 7 edges after reset deasserts.

Source files
------------

// File: rtl/light_btn_ctrl.sv
// light_btn_ctrl: push-button front end for the light-level FSM.
// Each raw button (up/down/off) is synchronised, debounced and turned into a
// one-hot single-cycle command pulse. Simultaneous presses are arbitrated
// (off > down > up). After one pulse, no further pulse is issued until every
// button has been released. While the light is on and nothing is pressed,
// an idle timer issues an automatic "off" pulse flagged by o_timeout.
//
// Handshake: o_button and o_timeout are plain registered strobes with no
// back-pressure. A nonzero o_button is valid for exactly the one cycle it is
// high. The consumer must take it in that cycle.
module light_btn_ctrl #(
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int IDLE_TIMEOUT    = 500000000
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [2:0] i_btn_raw,
  input  logic [2:0] i_light_level,
  output logic [2:0] o_button,
  output logic       o_timeout,
  output logic [2:0] o_btn_stable
);

  // The debounce counter only ever holds 0..DEBOUNCE_CYCLES-1.
  // The idle counter only ever holds 0..IDLE_TIMEOUT-1.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int IW = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [CW-1:0] DB_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'((IDLE_TIMEOUT > 0) ? IDLE_TIMEOUT - 1 : 0);
  localparam bit            IDLE_EN   = (IDLE_TIMEOUT != 0);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  logic [2:0]    sync1_q, sync2_q;
  logic [2:0]    stable_q, stable_d;
  logic [2:0]    stable_prev_q;
  logic [CW-1:0] db_cnt_q [3];
  logic [CW-1:0] db_cnt_d [3];
  logic [2:0]    ev;

  state_e        state_q, state_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          expired_q, expired_d;
  logic          count_en;

  logic [2:0]    button_q, button_d;
  logic          timeout_q, timeout_d;

  // Two-flop synchroniser for the asynchronous raw buttons.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sync1_q <= 3'b000;
      sync2_q <= 3'b000;
    end else begin
      sync1_q <= i_btn_raw;
      sync2_q <= sync1_q;
    end
  end

  // Per-bit debounce: count cycles of disagreement; flip the level on the
  // cycle the count would reach DEBOUNCE_CYCLES. Any agreement restarts it.
  always_comb begin
    stable_d = stable_q;
    for (int n = 0; n < 3; n++) begin
      db_cnt_d[n] = '0;
      if (sync2_q[n] != stable_q[n]) begin
        if (db_cnt_q[n] == DB_LAST) begin
          stable_d[n] = ~stable_q[n];
          db_cnt_d[n] = '0;
        end else begin
          db_cnt_d[n] = db_cnt_q[n] + CW'(1);
        end
      end
    end
  end

  // Debounce state registers; stable_prev_q lets us spot rising edges.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      stable_q      <= 3'b000;
      stable_prev_q <= 3'b000;
      for (int n = 0; n < 3; n++) db_cnt_q[n] <= '0;
    end else begin
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      for (int n = 0; n < 3; n++) db_cnt_q[n] <= db_cnt_d[n];
    end
  end

  // A press event is the cycle in which a debounced level has just risen.
  assign ev = stable_q & ~stable_prev_q;

  // FSM state register.
  always_ff @(posedge i_clk) begin
    if (i_reset) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // FSM next state: a press moves to HOLD, full release returns to IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (|ev) state_d = ST_HOLD;
      ST_HOLD: if (stable_q == 3'b000) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs: arbitrated press pulse, else auto-off when the timer expired.
  always_comb begin
    button_d  = 3'b000;
    timeout_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if (ev[2])          button_d = 3'b100;
      else if (ev[1])     button_d = 3'b010;
      else if (ev[0])     button_d = 3'b001;
      else if (expired_q) begin
        button_d  = 3'b100;
        timeout_d = 1'b1;
      end
    end
  end

  // Idle timer: runs only while idle with the light on. It clears whenever a
  // press or an auto-off is issued. Reaching IDLE_TIMEOUT-1 arms expired_q,
  // which fires the auto-off on the following cycle unless a press wins.
  always_comb begin
    count_en  = IDLE_EN && (state_q == ST_IDLE) && (i_light_level != 3'd0)
                && !(|ev) && !expired_q;
    idle_d    = '0;
    expired_d = 1'b0;
    if (count_en) begin
      if (idle_q == IDLE_LAST) begin
        expired_d = 1'b1;
      end else begin
        idle_d = idle_q + IW'(1);
      end
    end
  end

  // Idle timer and registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      idle_q    <= '0;
      expired_q <= 1'b0;
      button_q  <= 3'b000;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      expired_q <= expired_d;
      button_q  <= button_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_button     = button_q;
  assign o_timeout    = timeout_q;
  assign o_btn_stable = stable_q;

endmodule

// File: tb/tb_light_btn_ctrl.sv
// Bench for light_btn_ctrl with DEBOUNCE_CYCLES=4 and IDLE_TIMEOUT=20.
// Inputs are driven on the falling edge. cyc counts rising edges, so a raw
// change driven at cyc=c is first sampled at rising edge c+1. Its pulse is
// visible at the falling edge where cyc=c+7.
module tb_light_btn_ctrl;

  localparam int DB = 4;
  localparam int TO = 20;
  localparam int W  = 36;  // {cycle[31:0], button[2:0], timeout}

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] raw;
  logic [2:0] level;
  logic [2:0] button;
  logic       timeout;
  logic [2:0] stable;

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  int c;
  logic [W-1:0] exp_q[$];

  light_btn_ctrl #(
    .DEBOUNCE_CYCLES(DB),
    .IDLE_TIMEOUT(TO)
  ) dut (
    .i_clk(clk),
    .i_reset(rst),
    .i_btn_raw(raw),
    .i_light_level(level),
    .o_button(button),
    .o_timeout(timeout),
    .o_btn_stable(stable)
  );

  // Clock and reset.
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  // Driver helpers.
  task automatic wait_to(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic expect_pulse(input int at, input logic [2:0] b, input logic t);
    logic [31:0] at32;
    at32 = at;
    exp_q.push_back({at32, b, t});
  endtask

  task automatic check3(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%b expected=%b", name, cyc, act, exp);
    end
  endtask

  // Scoreboard monitor: every nonzero strobe must match the queue head,
  // including the cycle. A head that goes overdue is reported as missing.
  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [31:0]  cyc32;
    cyc32 = cyc;
    if (button !== 3'b000 || timeout !== 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse cyc=%0d actual button=%b timeout=%b expected none",
                 cyc, button, timeout);
      end else begin
        e = exp_q.pop_front();
        if ({cyc32, button, timeout} !== e) begin
          failures++;
          $display("FAIL pulse cyc=%0d actual button=%b timeout=%b expected cyc=%0d button=%b timeout=%b",
                   cyc, button, timeout, e[35:4], e[3:1], e[0]);
        end
      end
    end else if (exp_q.size() > 0 && exp_q[0][35:4] < cyc32) begin
      e = exp_q.pop_front();
      checks++;
      failures++;
      $display("FAIL missing_pulse cyc=%0d actual none expected cyc=%0d button=%b timeout=%b",
               cyc, e[35:4], e[3:1], e[0]);
    end
  end

  // Directed stimulus.
  initial begin
    rst   = 1'b1;
    raw   = 3'b000;
    level = 3'd0;

    // Reset state.
    wait_to(3);
    check3("reset_stable", stable, 3'b000);
    check3("reset_button", button, 3'b000);
    check3("reset_timeout", {2'b00, timeout}, 3'b000);
    rst = 1'b0;
    wait_to(6);

    // Single press of "up" held for 10 cycles: one pulse, none on release.
    c = cyc;
    raw = 3'b001;
    expect_pulse(c + 7, 3'b001, 1'b0);
    wait_to(c + 5);  check3("single_stable_pre", stable, 3'b000);
    wait_to(c + 6);  check3("single_stable_rise", stable, 3'b001);
    wait_to(c + 10); raw = 3'b000;
    wait_to(c + 15); check3("single_stable_held", stable, 3'b001);
    wait_to(c + 16); check3("single_stable_fall", stable, 3'b000);
    wait_to(c + 20);

    // Glitches on "down" shorter than the debounce window.
    c = cyc;
    raw = 3'b010;
    wait_to(c + 3); raw = 3'b000;
    wait_to(c + 5); raw = 3'b010;
    wait_to(c + 8); raw = 3'b000;
    for (int k = 1; k <= 16; k++) begin
      wait_to(c + k);
      check3("glitch_stable", stable, 3'b000);
    end
    wait_to(c + 20);

    // Simultaneous up+down: down wins. Re-press without full release is
    // ignored. A press after full release works again.
    c = cyc;
    raw = 3'b011;
    expect_pulse(c + 7, 3'b010, 1'b0);
    wait_to(c + 6);  check3("simul_stable", stable, 3'b011);
    wait_to(c + 8);  raw = 3'b110;
    wait_to(c + 15); check3("simul_hold_stable", stable, 3'b110);
    wait_to(c + 20); raw = 3'b000;
    wait_to(c + 26); check3("simul_released", stable, 3'b000);
    wait_to(c + 30); raw = 3'b001;
    expect_pulse(c + 37, 3'b001, 1'b0);
    wait_to(c + 40); raw = 3'b000;
    wait_to(c + 50);

    // Auto-off with the light on, twice, then silence with the light off.
    c = cyc;
    level = 3'd3;
    expect_pulse(c + 21, 3'b100, 1'b1);
    expect_pulse(c + 42, 3'b100, 1'b1);
    wait_to(c + 45); level = 3'd0;
    wait_to(c + 150);

    // Press edge lands in the cycle the idle count sits at 19. The press
    // wins. The next auto-off comes only after release plus the full idle
    // period.
    c = cyc;
    level = 3'd3;
    wait_to(c + 13); raw = 3'b001;
    expect_pulse(c + 20, 3'b001, 1'b0);
    wait_to(c + 21); check3("collide_no_timeout", {2'b00, timeout}, 3'b000);
    wait_to(c + 25); raw = 3'b000;
    expect_pulse(c + 53, 3'b100, 1'b1);
    wait_to(c + 55); level = 3'd0;
    wait_to(c + 60);

    // Reset while "off" is held, right after it debounces. The pending pulse
    // is dropped. A fresh pulse follows the re-debounce.
    c = cyc;
    raw = 3'b100;
    wait_to(c + 6);  check3("rst_stable_pre", stable, 3'b100);
    rst = 1'b1;
    wait_to(c + 7);  check3("rst_stable_0", stable, 3'b000);
                     check3("rst_button_0", button, 3'b000);
    wait_to(c + 8);  check3("rst_stable_1", stable, 3'b000);
                     check3("rst_timeout_1", {2'b00, timeout}, 3'b000);
    rst = 1'b0;
    expect_pulse(c + 15, 3'b100, 1'b0);
    wait_to(c + 14); check3("rst_redebounce", stable, 3'b100);
    wait_to(c + 20); raw = 3'b000;
    wait_to(c + 35);

    // Every expected pulse must have been consumed.
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover_expected actual=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
